// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for load-use, taken-branch and slow data-memory cases.
//   in : clk, rst (sync, active-low), id_rs1/rs2 addr+used, exe_write_addr_o, exe_DM_read,
//        exe_branch_taken, mem_req, mem_ack
//   out: pc_stall, ifid_stall, ifid_flush, idexe_stall, idexe_flush, exemem_stall,
//        memwb_bubble, mem_err (sticky), stall_cnt (saturating pc_stall cycles)
module hazard_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] id_rs1_addr,
  input  logic              id_rs1_used,
  input  logic [ADDR_W-1:0] id_rs2_addr,
  input  logic              id_rs2_used,
  input  logic [ADDR_W-1:0] exe_write_addr_o,
  input  logic              exe_DM_read,
  input  logic              exe_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idexe_stall,
  output logic              idexe_flush,
  output logic              exemem_stall,
  output logic              memwb_bubble,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, BR_HOLD} state_t;
  state_t state, state_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic err_nx, timeout_hit, lu_hit, freeze, br, lu, done;
  always_comb begin
    // wait_cnt holds the number of frozen cycles already spent, so the release
    // lands on the cycle after TIMEOUT frozen cycles.
    timeout_hit = state == MEM_WAIT && wait_cnt == 8'(TIMEOUT);
    lu_hit = exe_DM_read && exe_write_addr_o != '0 &&
             ((id_rs1_used && id_rs1_addr == exe_write_addr_o) ||
              (id_rs2_used && id_rs2_addr == exe_write_addr_o));
    freeze = rst && mem_req && !mem_ack && !timeout_hit;
    br = rst && exe_branch_taken && !freeze && state != BR_HOLD;
    lu = rst && lu_hit && !freeze && !exe_branch_taken && state != BR_HOLD;
    pc_stall = freeze || lu;
    ifid_stall = freeze || lu;
    ifid_flush = br;
    idexe_stall = freeze;
    idexe_flush = br || lu;
    exemem_stall = freeze;
    memwb_bubble = freeze;
    done = mem_ack || timeout_hit;
    state_nx = RUN;
    wait_nx = wait_cnt;
    err_nx = mem_err;
    if (state == RUN) begin
      state_nx = freeze ? MEM_WAIT : br ? BR_HOLD : RUN;
      wait_nx = freeze ? 8'd1 : wait_cnt;
    end else if (state == MEM_WAIT) begin
      state_nx = done ? RUN : MEM_WAIT;
      wait_nx = done ? 8'd0 : wait_cnt + 8'd1;
      err_nx = mem_err || (timeout_hit && !mem_ack);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      wait_cnt <= '0;
      mem_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
      mem_err <= err_nx;
      stall_cnt <= stall_cnt + CNT_W'(pc_stall && !(&stall_cnt));
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table, saturation run and random stimulus against a behavioural model.
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 6;
  localparam logic [6:0] F = 7'b1101011;
  localparam logic [6:0] L = 7'b1100100;
  localparam logic [6:0] B = 7'b0010100;
  localparam logic [6:0] N = 7'b0000000;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, id_rs1_used, id_rs2_used, exe_DM_read, exe_branch_taken, mem_req, mem_ack;
  logic [4:0] id_rs1_addr, id_rs2_addr, exe_write_addr_o;
  logic pc_stall, ifid_stall, ifid_flush, idexe_stall, idexe_flush, exemem_stall, memwb_bubble, mem_err;
  logic [CW-1:0] stall_cnt;
  hazard_ctrl #(.ADDR_W(5), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .exe_write_addr_o(exe_write_addr_o), .exe_DM_read(exe_DM_read),
    .exe_branch_taken(exe_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idexe_stall(idexe_stall), .idexe_flush(idexe_flush), .exemem_stall(exemem_stall),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );
  typedef struct {
    logic r; logic [4:0] a1; logic u1; logic [4:0] a2; logic u2; logic [4:0] wa;
    logic ld; logic tk; logic rq; logic ak; logic [6:0] ctl; logic err; int cnt;
  } vec_t;
  vec_t tbl[$];
  int vectors = 0, miscompares = 0;
  bit waiting = 0, hold = 0, m_err = 0;
  int waited = 0, m_stalls = 0;
  function automatic vec_t mk(logic r, logic [4:0] a1, logic u1, logic [4:0] a2, logic u2,
                              logic [4:0] wa, logic ld, logic tk, logic rq, logic ak,
                              logic [6:0] ctl, logic err, int cnt);
    vec_t v;
    v.r = r; v.a1 = a1; v.u1 = u1; v.a2 = a2; v.u2 = u2; v.wa = wa;
    v.ld = ld; v.tk = tk; v.rq = rq; v.ak = ak; v.ctl = ctl; v.err = err; v.cnt = cnt;
    return v;
  endfunction
  task automatic check(input string nm, input logic [6:0] e_ctl, input logic e_err, input int e_cnt);
    logic [6:0] a_ctl;
    a_ctl = {pc_stall, ifid_stall, ifid_flush, idexe_stall, idexe_flush, exemem_stall, memwb_bubble};
    vectors++;
    if (a_ctl !== e_ctl || mem_err !== e_err || stall_cnt !== CW'(e_cnt)) begin
      miscompares++;
      $display("FAIL %s: got ctl=%b err=%b cnt=%0d, expected ctl=%b err=%b cnt=%0d",
               nm, a_ctl, mem_err, stall_cnt, e_ctl, e_err, e_cnt);
    end
  endtask
  task automatic apply(input vec_t v, input bit has_exp, input string nm);
    bit luh, to, frz, br, lu;
    logic [6:0] m_ctl;
    rst = v.r; id_rs1_addr = v.a1; id_rs1_used = v.u1; id_rs2_addr = v.a2; id_rs2_used = v.u2;
    exe_write_addr_o = v.wa; exe_DM_read = v.ld; exe_branch_taken = v.tk;
    mem_req = v.rq; mem_ack = v.ak;
    luh = v.ld && v.wa != 0 && ((v.u1 && v.a1 == v.wa) || (v.u2 && v.a2 == v.wa));
    to = waiting && waited == TO;
    frz = v.r && v.rq && !v.ak && !to;
    br = v.r && v.tk && !frz && !hold;
    lu = v.r && luh && !frz && !v.tk && !hold;
    m_ctl = {frz | lu, frz | lu, br, frz, br | lu, frz, frz};
    @(negedge clk);
    check({nm, "/model"}, m_ctl, m_err, m_stalls);
    if (has_exp) check({nm, "/table"}, v.ctl, v.err, v.cnt);
    @(posedge clk);
    if (!v.r) begin
      waiting = 0; waited = 0; hold = 0; m_err = 0; m_stalls = 0;
    end else begin
      if (frz || lu) m_stalls = (m_stalls + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_stalls + 1;
      if (hold) hold = 0;
      else if (waiting) begin
        if (v.ak) waiting = 0;
        else if (to) begin waiting = 0; m_err = 1; end
        else waited++;
      end else if (frz) begin waiting = 1; waited = 1; end
      else if (br) hold = 1;
    end
    #1;
  endtask
  initial begin
    vec_t v;
    rst = 0; id_rs1_addr = 0; id_rs1_used = 0; id_rs2_addr = 0; id_rs2_used = 0;
    exe_write_addr_o = 0; exe_DM_read = 0; exe_branch_taken = 0; mem_req = 0; mem_ack = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 5, 1, 5, 1, 5, 1, 1, 1, 0, N, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0));
    tbl.push_back(mk(1, 0, 0, 5, 1, 5, 1, 0, 0, 0, L, 0, 0));
    tbl.push_back(mk(1, 0, 0, 5, 1, 5, 0, 0, 0, 0, N, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, N, 0, 1));
    tbl.push_back(mk(1, 7, 1, 0, 0, 7, 1, 0, 0, 0, L, 0, 1));
    tbl.push_back(mk(1, 7, 0, 0, 0, 7, 1, 0, 0, 0, N, 0, 2));
    tbl.push_back(mk(1, 0, 0, 5, 1, 5, 1, 1, 0, 0, B, 0, 2));
    tbl.push_back(mk(1, 0, 0, 5, 1, 5, 1, 1, 0, 0, N, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, F, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, F, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, F, 0, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, N, 0, 5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, F, 0, 5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, F, 0, 6));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, B, 0, 7));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 7));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, F, 0, 7 + i));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, N, 0, 11));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 1, 11));
    tbl.push_back(mk(1, 0, 0, 5, 1, 5, 1, 0, 0, 0, L, 1, 11));
    tbl.push_back(mk(0, 0, 0, 5, 1, 5, 1, 0, 0, 0, N, 1, 12));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, B, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, N, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, B, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1, $sformatf("vec%0d", i));
    for (int i = 0; i < 70; i++) apply(mk(1, 0, 0, 9, 1, 9, 1, 0, 0, 0, N, 0, 0), 0, "sat");
    vectors++;
    if (stall_cnt !== {CW{1'b1}}) begin
      miscompares++;
      $display("FAIL sat_final: got cnt=%0d, expected cnt=%0d", stall_cnt, (1 << CW) - 1);
    end
    for (int i = 0; i < 500; i++) begin
      v = mk($urandom_range(0, 31) != 0, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, N, 0, 0);
      apply(v, 0, $sformatf("rnd%0d", i));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
